// File: rtl/uarc_bus_receiver.sv
// uarc_bus_receiver: UARC bus receive endpoint, tagged FIFO toward core dispatch; optional UARC_RX_PERMISSION_CHECK_EN
module uarc_bus_receiver #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             bus_enable,
   input  logic             bus_kill,
   output logic             bus_kill_ack,
   input  logic             bus_incept,
   output logic             bus_incept_ack,
   input  logic             bus_stream,
   output logic             bus_stream_ack,
   input  logic             bus_send,
   output logic             bus_send_ack,
   input  logic [WIDTH-1:0] bus_data,
   input  logic [WIDTH-1:0] bus_self_permission,
   input  logic [WIDTH-1:0] bus_self_address,
   input  logic [WIDTH-1:0] bus_incept_permission,
   input  logic [WIDTH-1:0] bus_incept_address,
   input  logic             core_idle,
   input  logic [WIDTH-1:0] core_permission,
   output logic             core_kill,
   output logic             core_incept,
   output logic [WIDTH-1:0] core_incept_permission,
   output logic [WIDTH-1:0] core_incept_address,
   output logic             core_valid,
   input  logic             core_ready,
   output logic [1:0]       core_kind,
   output logic [WIDTH-1:0] core_data,
   output logic             core_denied
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, INCEPT, STREAM, END_PUSH} state_t;
   state_t           state;
   logic             drop;
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic [WIDTH+1:0] mem [DEPTH];
   logic             en, kill, inc_r, str_r, snd_r, pop, accept, ack, fresh, denied;
   logic             drop_now, end_push, push, start_incept, unused_bits;
   logic [WIDTH+1:0] push_word;

   // requests are masked while reset is held so every output reads 0 during reset
   assign en    = bus_enable & ~reset;
   assign kill  = en & bus_kill;
   assign inc_r = en & bus_incept;
   assign str_r = en & bus_stream;
   assign snd_r = en & bus_send;

   assign core_valid = count != '0;
   assign pop        = core_valid & core_ready;
   assign accept     = (count != (AW+1)'(DEPTH)) | pop;
   assign {core_kind, core_data} = core_valid ? mem[rd_ptr] : '0;

   assign bus_kill_ack   = kill;
   assign bus_incept_ack = ~kill & inc_r & accept & ((state == INCEPT) | ((state == IDLE) & core_idle));
   assign bus_stream_ack = ~kill & str_r & accept & ((state == STREAM) | ((state == IDLE) & ~inc_r));
   assign bus_send_ack   = ~kill & snd_r & accept & (state == IDLE) & ~inc_r & ~str_r;

   // a fresh ack in IDLE opens a new request; its permission verdict sticks for the whole transfer
   assign ack          = bus_incept_ack | bus_stream_ack | bus_send_ack;
   assign fresh        = ack & (state == IDLE);
   assign drop_now     = fresh ? denied : drop;
   assign start_incept = bus_incept_ack & fresh & ~denied;
   assign end_push     = (state == END_PUSH) & accept & ~kill;
   assign push         = (ack & ~drop_now) | end_push;
   assign push_word    = end_push ? {2'd3, {WIDTH{1'b0}}}
                                  : {bus_incept_ack ? 2'd2 : bus_stream_ack ? 2'd1 : 2'd0, bus_data};

`ifdef UARC_RX_PERMISSION_CHECK_EN
   assign denied      = (bus_self_permission & core_permission) == '0;
   assign unused_bits = ^bus_self_address;
`else
   assign denied      = 1'b0;
   assign unused_bits = ^{bus_self_address, bus_self_permission, core_permission};
`endif

   // FIFO storage; contents are only visible through the valid-gated head
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= push_word;

   // control FSM, FIFO pointers and registered pulses toward the core
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state                  <= IDLE;
         drop                   <= 1'b0;
         wr_ptr                 <= '0;
         rd_ptr                 <= '0;
         count                  <= '0;
         core_kill              <= 1'b0;
         core_incept            <= 1'b0;
         core_denied            <= 1'b0;
         core_incept_permission <= '0;
         core_incept_address    <= '0;
      end else begin
         core_kill   <= kill;
         core_incept <= start_incept;
         core_denied <= fresh & denied;
         if (start_incept) begin
            core_incept_permission <= bus_incept_permission;
            core_incept_address    <= bus_incept_address;
         end
         if (kill) begin
            state  <= IDLE;
            drop   <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
            case (state)
               IDLE:    if (bus_incept_ack | bus_stream_ack) begin
                           state <= bus_incept_ack ? INCEPT : STREAM;
                           drop  <= denied;
                        end
               INCEPT:  if (~inc_r) state <= drop ? IDLE : END_PUSH;
               STREAM:  if (~str_r) state <= drop ? IDLE : END_PUSH;
               default: if (accept) state <= IDLE;
            endcase
         end
      end
endmodule

// File: tb/tb_uarc_bus_receiver.sv
// tb_uarc_bus_receiver: directed scenarios plus randomized run against a queue-based reference model
module tb_uarc_bus_receiver;
   localparam int WIDTH = 32;
   localparam int DEPTH = 8;

   logic             clk = 1'b0;
   logic             reset, bus_enable, bus_kill, bus_incept, bus_stream, bus_send, core_idle, core_ready;
   logic             bus_kill_ack, bus_incept_ack, bus_stream_ack, bus_send_ack;
   logic             core_kill, core_incept, core_valid, core_denied;
   logic [1:0]       core_kind;
   logic [WIDTH-1:0] bus_data, bus_self_permission, bus_self_address, bus_incept_permission;
   logic [WIDTH-1:0] bus_incept_address, core_permission, core_incept_permission, core_incept_address, core_data;
   logic             any_out;
   int               checks = 0;
   int               errors = 0;

   always #5 clk = ~clk;

   uarc_bus_receiver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .bus_enable(bus_enable),
      .bus_kill(bus_kill), .bus_kill_ack(bus_kill_ack),
      .bus_incept(bus_incept), .bus_incept_ack(bus_incept_ack),
      .bus_stream(bus_stream), .bus_stream_ack(bus_stream_ack),
      .bus_send(bus_send), .bus_send_ack(bus_send_ack),
      .bus_data(bus_data), .bus_self_permission(bus_self_permission),
      .bus_self_address(bus_self_address), .bus_incept_permission(bus_incept_permission),
      .bus_incept_address(bus_incept_address), .core_idle(core_idle),
      .core_permission(core_permission), .core_kill(core_kill), .core_incept(core_incept),
      .core_incept_permission(core_incept_permission), .core_incept_address(core_incept_address),
      .core_valid(core_valid), .core_ready(core_ready), .core_kind(core_kind),
      .core_data(core_data), .core_denied(core_denied)
   );

   assign any_out = |{bus_kill_ack, bus_incept_ack, bus_stream_ack, bus_send_ack, core_kill, core_incept,
                      core_incept_permission, core_incept_address, core_valid, core_kind, core_data, core_denied};

   // reference model: expected FIFO as a queue of {kind,data}, transfer phase as 0 idle/1 incept/2 stream/3 end
   int               mst;
   logic [WIDTH+1:0] q[$];
   logic             e_kack, e_iack, e_sack, e_dack, e_valid, e_pop, e_acc, e_ck, e_ci;
   logic [1:0]       e_kind;
   logic [WIDTH-1:0] e_data, e_ip, e_ia;

   function void m_reset();
      q.delete();
      mst  = 0;
      e_ck = 1'b0;
      e_ci = 1'b0;
      e_ip = '0;
      e_ia = '0;
   endfunction

   function void predict();
      e_valid = q.size() != 0;
      e_pop   = e_valid && core_ready;
      e_acc   = q.size() < DEPTH || e_pop;
      e_kind  = e_valid ? q[0][WIDTH+1:WIDTH] : 2'd0;
      e_data  = e_valid ? q[0][WIDTH-1:0] : '0;
      e_kack  = bus_enable && bus_kill;
      e_iack  = 1'b0;
      e_sack  = 1'b0;
      e_dack  = 1'b0;
      if (!e_kack && bus_enable)
         case (mst)
            0: if (bus_incept) e_iack = core_idle && e_acc;
               else if (bus_stream) e_sack = e_acc;
               else if (bus_send) e_dack = e_acc;
            1: e_iack = bus_incept && e_acc;
            2: e_sack = bus_stream && e_acc;
            default: ;
         endcase
   endfunction

   function void commit();
      e_ck = e_kack;
      e_ci = mst == 0 && e_iack;
      if (e_ci) begin
         e_ip = bus_incept_permission;
         e_ia = bus_incept_address;
      end
      if (e_kack) begin
         q.delete();
         mst = 0;
         return;
      end
      if (e_pop) void'(q.pop_front());
      if (e_iack) q.push_back({2'd2, bus_data});
      if (e_sack) q.push_back({2'd1, bus_data});
      if (e_dack) q.push_back({2'd0, bus_data});
      case (mst)
         0: mst = e_iack ? 1 : e_sack ? 2 : 0;
         1: if (!(bus_enable && bus_incept)) mst = 3;
         2: if (!(bus_enable && bus_stream)) mst = 3;
         default: if (e_acc) begin
            q.push_back({2'd3, {WIDTH{1'b0}}});
            mst = 0;
         end
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      bus_enable = 1'b1; bus_kill = 1'b0; bus_incept = 1'b0; bus_stream = 1'b0; bus_send = 1'b0;
      core_idle = 1'b1; core_ready = 1'b1; bus_data = '0;
      bus_self_permission = '1; core_permission = '1; bus_self_address = '0;
      bus_incept_permission = '0; bus_incept_address = '0;
   endtask

   task automatic test_reset();
      quiet();
      bus_enable = 1'b0;
      reset = 1'b1;
      tick();
      checks++;
      if (any_out !== 1'b0) begin errors++; $display("FAIL reset_hold outputs_nonzero got %0b want 0", any_out); end
      reset = 1'b0;
      tick();
      checks++;
      if (any_out !== 1'b0) begin errors++; $display("FAIL reset_release outputs_nonzero got %0b want 0", any_out); end
   endtask

   task automatic test_send();
      quiet();
      bus_send = 1'b1;
      bus_data = 32'hDEADBEEF;
      @(negedge clk);
      checks++;
      if (bus_send_ack !== 1'b1) begin errors++; $display("FAIL send_ack got %0b want 1", bus_send_ack); end
      tick();
      bus_send = 1'b0;
      checks++;
      if ({core_valid, core_kind, core_data} !== {1'b1, 2'd0, 32'hDEADBEEF})
         begin errors++; $display("FAIL send_head got %0b/%0d/%0h want 1/0/deadbeef", core_valid, core_kind, core_data); end
      tick();
      tick();
   endtask

   task automatic test_stream();
      int               i, n;
      logic             a;
      logic [WIDTH+1:0] got[$];
      logic [WIDTH+1:0] exp_w;
      quiet();
      core_ready = 1'b0;
      bus_stream = 1'b1;
      i = 0;
      bus_data = 32'h1000;
      repeat (12) begin
         @(negedge clk);
         a = bus_stream_ack;
         tick();
         if (a) begin i++; bus_data = WIDTH'(32'h1000 + i); end
      end
      checks++;
      if (i != DEPTH) begin errors++; $display("FAIL stream_fill_acks got %0d want %0d", i, DEPTH); end
      @(negedge clk);
      checks++;
      if (bus_stream_ack !== 1'b0) begin errors++; $display("FAIL stream_full_ack got %0b want 0", bus_stream_ack); end
      tick();
      core_ready = 1'b1;
      repeat (30) begin
         @(negedge clk);
         if (core_valid) got.push_back({core_kind, core_data});
         a = bus_stream_ack;
         tick();
         if (a) begin
            i++;
            bus_data = WIDTH'(32'h1000 + i);
            if (i == 10) bus_stream = 1'b0;
         end
      end
      checks++;
      if (i != 10) begin errors++; $display("FAIL stream_total_acks got %0d want 10", i); end
      checks++;
      if (got.size() != 11) begin errors++; $display("FAIL stream_out_count got %0d want 11", got.size()); end
      n = got.size() < 11 ? got.size() : 11;
      for (int k = 0; k < n; k++) begin
         exp_w = k < 10 ? {2'd1, WIDTH'(32'h1000 + k)} : {2'd3, {WIDTH{1'b0}}};
         checks++;
         if (got[k] !== exp_w) begin errors++; $display("FAIL stream_word%0d got %0h want %0h", k, got[k], exp_w); end
      end
   endtask

   task automatic test_incept();
      int               i, pulses, n;
      logic             a;
      logic [WIDTH+1:0] got[$];
      logic [WIDTH+1:0] exp_w;
      quiet();
      core_idle = 1'b0;
      bus_incept = 1'b1;
      bus_incept_address = 32'h100;
      bus_incept_permission = 32'h5;
      bus_data = 32'h2000;
      pulses = 0;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (bus_incept_ack !== 1'b0) begin errors++; $display("FAIL incept_busy_ack got %0b want 0", bus_incept_ack); end
         tick();
      end
      core_idle = 1'b1;
      i = 0;
      repeat (20) begin
         @(negedge clk);
         if (core_incept) pulses++;
         if (core_valid) got.push_back({core_kind, core_data});
         a = bus_incept_ack;
         tick();
         if (a) begin
            i++;
            bus_data = WIDTH'(32'h2000 + i);
            bus_incept_address = 32'hFFF;
            bus_incept_permission = 32'hF;
            if (i == 3) bus_incept = 1'b0;
         end
      end
      checks++;
      if (pulses != 1) begin errors++; $display("FAIL incept_pulses got %0d want 1", pulses); end
      checks++;
      if (core_incept_address !== 32'h100) begin errors++; $display("FAIL incept_addr got %0h want 100", core_incept_address); end
      checks++;
      if (core_incept_permission !== 32'h5) begin errors++; $display("FAIL incept_perm got %0h want 5", core_incept_permission); end
      checks++;
      if (got.size() != 4) begin errors++; $display("FAIL incept_out_count got %0d want 4", got.size()); end
      n = got.size() < 4 ? got.size() : 4;
      for (int k = 0; k < n; k++) begin
         exp_w = k < 3 ? {2'd2, WIDTH'(32'h2000 + k)} : {2'd3, {WIDTH{1'b0}}};
         checks++;
         if (got[k] !== exp_w) begin errors++; $display("FAIL incept_word%0d got %0h want %0h", k, got[k], exp_w); end
      end
   endtask

   task automatic test_kill();
      int   i;
      logic a;
      quiet();
      core_ready = 1'b0;
      bus_incept = 1'b1;
      i = 0;
      repeat (10) if (i < 4) begin
         @(negedge clk);
         a = bus_incept_ack;
         tick();
         if (a) begin i++; bus_data = WIDTH'(32'h3000 + i); end
      end
      checks++;
      if (i != 4) begin errors++; $display("FAIL kill_prefill got %0d want 4", i); end
      bus_kill = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus_kill_ack, bus_incept_ack} !== 2'b10)
         begin errors++; $display("FAIL kill_acks got %0b%0b want 10", bus_kill_ack, bus_incept_ack); end
      tick();
      bus_kill = 1'b0;
      bus_incept = 1'b0;
      checks++;
      if ({core_kill, core_valid} !== 2'b10)
         begin errors++; $display("FAIL kill_after got kill=%0b valid=%0b want 1/0", core_kill, core_valid); end
      tick();
      checks++;
      if (core_kill !== 1'b0) begin errors++; $display("FAIL kill_pulse_len got %0b want 0", core_kill); end
      core_ready = 1'b1;
      bus_send = 1'b1;
      bus_data = 32'h55;
      @(negedge clk);
      checks++;
      if (bus_send_ack !== 1'b1) begin errors++; $display("FAIL kill_then_send_ack got %0b want 1", bus_send_ack); end
      tick();
      bus_send = 1'b0;
      checks++;
      if ({core_valid, core_kind, core_data} !== {1'b1, 2'd0, 32'h55})
         begin errors++; $display("FAIL kill_then_send_head got %0b/%0d/%0h want 1/0/55", core_valid, core_kind, core_data); end
      tick();
      tick();
   endtask

`ifdef UARC_RX_PERMISSION_CHECK_EN
   task automatic test_permission();
      int   i, den, seen;
      logic a;
      quiet();
      core_permission = 32'h2;
      bus_self_permission = 32'h1;
      bus_stream = 1'b1;
      i = 0; den = 0; seen = 0;
      repeat (14) begin
         @(negedge clk);
         if (core_denied) den++;
         if (core_valid) seen++;
         a = bus_stream_ack;
         tick();
         if (a) begin
            i++;
            if (i == 4) bus_stream = 1'b0;
         end
      end
      checks++;
      if (i != 4) begin errors++; $display("FAIL perm_acks got %0d want 4", i); end
      checks++;
      if (den != 1) begin errors++; $display("FAIL perm_denied_pulses got %0d want 1", den); end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL perm_valid_cycles got %0d want 0", seen); end
   endtask
`endif

   task automatic test_random();
      quiet();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_reset();
      for (int c = 0; c < 420; c++) begin
         if (c < 400) begin
            bus_enable = $urandom % 8 != 0;
            bus_kill   = $urandom % 30 == 0;
            if ($urandom % 4 == 0) bus_incept = ~bus_incept;
            if ($urandom % 4 == 0) bus_stream = ~bus_stream;
            bus_send   = $urandom % 2;
            core_idle  = $urandom % 4 != 0;
            core_ready = $urandom % 2;
            bus_data   = $urandom;
            bus_incept_permission = $urandom;
            bus_incept_address    = $urandom;
         end else quiet();
         @(negedge clk);
         predict();
         checks++;
         if ({bus_kill_ack, bus_incept_ack, bus_stream_ack, bus_send_ack} !== {e_kack, e_iack, e_sack, e_dack})
            begin errors++; $display("FAIL rnd_acks c=%0d got %b%b%b%b want %b%b%b%b", c, bus_kill_ack, bus_incept_ack,
                                     bus_stream_ack, bus_send_ack, e_kack, e_iack, e_sack, e_dack); end
         checks++;
         if (core_valid !== e_valid) begin errors++; $display("FAIL rnd_valid c=%0d got %0b want %0b", c, core_valid, e_valid); end
         checks++;
         if (e_valid && {core_kind, core_data} !== {e_kind, e_data})
            begin errors++; $display("FAIL rnd_head c=%0d got %0d/%0h want %0d/%0h", c, core_kind, core_data, e_kind, e_data); end
         checks++;
         if ({core_kill, core_incept, core_denied} !== {e_ck, e_ci, 1'b0})
            begin errors++; $display("FAIL rnd_pulses c=%0d got %b%b%b want %b%b0", c, core_kill, core_incept, core_denied, e_ck, e_ci); end
         checks++;
         if ({core_incept_permission, core_incept_address} !== {e_ip, e_ia})
            begin errors++; $display("FAIL rnd_latched c=%0d got %0h/%0h want %0h/%0h", c, core_incept_permission,
                                     core_incept_address, e_ip, e_ia); end
         @(posedge clk);
         commit();
         #1;
      end
   endtask

   task automatic test_reset_mid_stream();
      int   i;
      logic a;
      quiet();
      core_ready = 1'b0;
      bus_stream = 1'b1;
      i = 0;
      repeat (6) if (i < 3) begin
         @(negedge clk);
         a = bus_stream_ack;
         tick();
         if (a) begin i++; bus_data = WIDTH'(32'h4000 + i); end
      end
      checks++;
      if (core_valid !== 1'b1) begin errors++; $display("FAIL midreset_prefill got %0b want 1", core_valid); end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (any_out !== 1'b0) begin errors++; $display("FAIL midreset_during got %0b want 0", any_out); end
      tick();
      bus_stream = 1'b0;
      bus_enable = 1'b0;
      reset = 1'b0;
      tick();
      checks++;
      if (any_out !== 1'b0 || core_valid !== 1'b0)
         begin errors++; $display("FAIL midreset_after got %0b/%0b want 0/0", any_out, core_valid); end
   endtask

   initial begin
      test_reset();
      test_send();
      test_stream();
      test_incept();
      test_kill();
`ifdef UARC_RX_PERMISSION_CHECK_EN
      test_permission();
`endif
      test_random();
      test_reset_mid_stream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uarc_bus_receiver.md
Name: uarc_bus_receiver

Overview:
- Receiver-side endpoint of the inter-core UARC bus; sits directly downstream of the sending core's outgoing bus.
- Arbitrates kill / incept / stream / send requests and drives their acknowledges.
- Buffers accepted words in a tagged FIFO and presents them to the local core's dispatch logic over a valid/ready interface.
- Produces kill and incept pulses toward the core.

Parameters:
WIDTH, 32, bus data/permission/address width
DEPTH, 8, FIFO entries (power of two, >=2)

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-high reset
bus_enable  input  1  bus enabled by sender
bus_kill  input  1  kill request
bus_kill_ack  output  1  kill acknowledge
bus_incept  input  1  inception request / program transfer in progress
bus_incept_ack  output  1  inception word accepted this cycle
bus_stream  input  1  stream request / stream in progress
bus_stream_ack  output  1  stream word accepted this cycle
bus_send  input  1  single-word send
bus_send_ack  output  1  send word accepted this cycle
bus_data  input  WIDTH  word from sender
bus_self_permission  input  WIDTH  sender permission
bus_self_address  input  WIDTH  sender address (unused except optional feature)
bus_incept_permission  input  WIDTH  permission for incepted program
bus_incept_address  input  WIDTH  start address for incepted program
core_idle  input  1  core may be incepted
core_permission  input  WIDTH  local permission mask (optional feature)
core_kill  output  1  one-cycle kill pulse to core
core_incept  output  1  one-cycle pulse: inception started
core_incept_permission  output  WIDTH  latched incept permission
core_incept_address  output  WIDTH  latched incept address
core_valid  output  1  FIFO head valid
core_ready  input  1  core consumes head
core_kind  output  2  head tag: 0 SEND, 1 STREAM, 2 PROGRAM, 3 END
core_data  output  WIDTH  head data (0 for END)
core_denied  output  1  one-cycle pulse: request refused (optional feature)

Behaviour:
- Reset values: all outputs 0; FIFO empty; state IDLE; latched incept registers 0.
- Acknowledges are combinational. An ack high in a cycle means bus_data is captured at that rising edge. The sender changes the word the next cycle.
- All requests are ignored while bus_enable is 0.
- States: IDLE, INCEPT, STREAM, END_PUSH.
- Priority in IDLE: kill > incept > stream > send.
- accept = FIFO not full, or a pop happens in the same cycle.
- Kill, any state:
  - bus_kill_ack = bus_enable & bus_kill; all other acks are 0 that cycle.
  - At the edge: FIFO flushed, state -> IDLE, core_kill=1 for the next cycle only.
  - A pending END marker is discarded.
- IDLE + incept:
  - Requires core_idle=1; otherwise no ack and requesting continues.
  - bus_incept_ack = accept. On the first ack: latch incept permission/address, pulse core_incept next cycle, push PROGRAM word, state -> INCEPT.
- INCEPT:
  - bus_incept=1: ack = accept; each ack pushes a PROGRAM word.
  - bus_incept=0: go to END_PUSH.
- IDLE + stream: ack = accept; first ack pushes a STREAM word, state -> STREAM.
- STREAM:
  - bus_stream=1: ack = accept; each ack pushes a STREAM word.
  - bus_stream=0: go to END_PUSH.
- END_PUSH: push an END entry when accept, then -> IDLE. Requests are not acked here.
- IDLE + send: bus_send_ack = accept; pushes a SEND word; stays IDLE.
- FIFO:
  - Pop when core_valid & core_ready. core_data/core_kind reflect the head combinationally.
  - Simultaneous push and pop when full is allowed.
  - Pointers wrap modulo DEPTH.
  - Count has log2(DEPTH)+1 bits.
- Full FIFO mid-transfer: ack held low and state unchanged. The sender holds its word.
- Asynchronous reset mid-transfer returns everything to the reset values immediately.

Optional Feature:
- Macro: UARC_RX_PERMISSION_CHECK_EN.
- Enabled:
  - A new send/stream/incept is denied when (bus_self_permission & core_permission)==0.
  - A denied request is still acked (accept rule) so the sender drains, but no words are pushed and no core_incept is pulsed.
  - The transfer is discarded until the request drops, with no END entry.
  - core_denied pulses once per denied request, on the first ack.
- Disabled: core_denied tied 0; core_permission ignored.

Test Plan:
- Reset asserted mid-stream with 3 words queued -> all outputs 0 and core_valid=0 during reset and after release.
- send with bus_data=0xDEADBEEF, FIFO empty, core_ready=1 -> bus_send_ack=1 same cycle; next cycle core_valid=1, core_kind=0, core_data=0xDEADBEEF.
- stream of 10 words, DEPTH=8, core_ready=0 -> acks on 8 cycles, then ack=0. Raise core_ready -> remaining 2 accepted. Words emerge in order as STREAM, followed by END after bus_stream drops.
- incept with core_idle=0 for 3 cycles then 1, incept_address=0x100, permission=0x5 -> no ack until core_idle=1. Then core_incept pulses once, latched values 0x100/0x5, PROGRAM words followed by END.
- kill during an incept with 4 words queued -> bus_kill_ack=1 that cycle. Next cycle core_kill=1 (one cycle only), core_valid=0, state IDLE. Subsequent send is accepted normally.
- With UARC_RX_PERMISSION_CHECK_EN, core_permission=0x2, sender permission=0x1, 4-word stream -> 4 acks, core_denied pulses once, core_valid stays 0, no END entry.
